// File: rtl/kbd_pkg.sv
// Shared scan-code constants, decode states and buffer entry type for the
// PS/2 key buffer.
package kbd_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ERR0  = 8'h00;
  localparam logic [7:0] SC_ERR1  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } kbd_state_e;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } kbd_entry_t;

  function automatic logic is_err_code(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

endpackage

// File: rtl/kbd_code_buffer_digit_scanner.sv
// Refresh divider and digit index for the multiplexed display; the enable
// is the active-low one-hot decode of the current index.
module digit_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [IDX_W-1:0]      idx_o,
  output logic [NUM_DIGITS-1:0] seg_en_n_o
);

  localparam int DIV_W = $clog2(REFRESH_DIV);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wrap;

  always_comb begin
    wrap  = (cnt_q == DIV_W'(REFRESH_DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
    idx_d = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o = idx_q;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_en
    assign seg_en_n_o[i] = (idx_q != IDX_W'(i));
  end

endmodule

// File: rtl/kbd_code_buffer.sv
// PS/2 set-2 release decoder feeding an N-deep key shift buffer, scanned onto
// an N-digit display. Define BLANK_EMPTY_EN to keep unfilled digits dark.
module kbd_code_buffer
  import kbd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = $clog2(NUM_DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_code,
  input  logic [7:0]            scan_code_in,
  output logic [7:0]            code_to_display,
  output logic                  ext_to_display,
  output logic [NUM_DIGITS-1:0] seg_en,
  output logic [CNT_W-1:0]      key_count
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  kbd_state_e state_q, state_d;
  logic       push;
  kbd_entry_t new_entry;

  kbd_entry_t [NUM_DIGITS-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]            key_count_q, key_count_d;

  logic [IDX_W-1:0]      idx;
  logic [NUM_DIGITS-1:0] en_n;
  logic                  blank;
  kbd_entry_t            sel;

  logic [NUM_DIGITS-1:0] seg_en_q, seg_en_d;
  logic [7:0]            code_q, code_d;
  logic                  ext_q, ext_d;

  // Only break sequences push; makes, extended makes and malformed pairs fall
  // back to IDLE so the next byte starts a fresh sequence.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    if (valid_code) begin
      if (is_err_code(scan_code_in)) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (scan_code_in == SC_BREAK)    state_d = BRK;
            else if (scan_code_in == SC_EXT) state_d = EXT;
          end
          EXT: begin
            state_d = (scan_code_in == SC_BREAK) ? EXT_BRK : IDLE;
          end
          BRK, EXT_BRK: begin
            state_d = IDLE;
            push    = (scan_code_in != SC_BREAK) && (scan_code_in != SC_EXT);
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    new_entry.ext  = (state_q == EXT_BRK);
    new_entry.code = scan_code_in;
    buf_d          = buf_q;
    key_count_d    = key_count_q;
    if (push) begin
      buf_d = {buf_q[NUM_DIGITS-2:0], new_entry};
      if (key_count_q != CNT_W'(NUM_DIGITS)) key_count_d = key_count_q + CNT_W'(1);
    end
  end

  digit_scanner #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .IDX_W      (IDX_W)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .idx_o     (idx),
    .seg_en_n_o(en_n)
  );

  always_comb begin
    sel = buf_q[idx];
`ifdef BLANK_EMPTY_EN
    blank = (CNT_W'(idx) >= key_count_q);
`else
    blank = 1'b0;
`endif
    seg_en_d = blank ? '1 : en_n;
    code_d   = blank ? 8'h00 : sel.code;
    ext_d    = blank ? 1'b0 : sel.ext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      key_count_q <= '0;
      seg_en_q    <= '1;
      code_q      <= 8'h00;
      ext_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      key_count_q <= key_count_d;
      seg_en_q    <= seg_en_d;
      code_q      <= code_d;
      ext_q       <= ext_d;
    end
  end

  assign code_to_display = code_q;
  assign ext_to_display  = ext_q;
  assign seg_en          = seg_en_q;
  assign key_count       = key_count_q;

endmodule

// File: tb/tb_kbd_code_buffer.sv
// Directed bench for kbd_code_buffer with 4 digits and a 4-cycle refresh slot.
module tb_kbd_code_buffer;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int CW = $clog2(ND + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_code = 1'b0;
  logic [7:0]    scan_code_in = 8'h00;
  logic [7:0]    code_to_display;
  logic          ext_to_display;
  logic [ND-1:0] seg_en;
  logic [CW-1:0] key_count;

  int tests = 0;
  int fails = 0;
  int edge_cnt;

  kbd_code_buffer #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_code     (valid_code),
    .scan_code_in   (scan_code_in),
    .code_to_display(code_to_display),
    .ext_to_display (ext_to_display),
    .seg_en         (seg_en),
    .key_count      (key_count)
  );

  always #5 clk = ~clk;

  // Edges seen since reset release; the scan index is a pure function of it.
  always @(posedge clk or negedge rst)
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    valid_code   = 1'b1;
    scan_code_in = b;
    @(negedge clk);
    valid_code   = 1'b0;
    scan_code_in = 8'h00;
  endtask

  task automatic brk(input logic [7:0] b);
    send(8'hF0);
    send(b);
  endtask

  // Wait for digit d's slot, then check what it shows.
  task automatic check_digit(input int d, input logic [7:0] c, input logic e, input string tag);
    logic [ND-1:0] want;
    bit found;
    want  = ~(4'b0001 << d);
    found = 0;
    for (int i = 0; i < 24 && !found; i++) begin
      @(negedge clk);
      if (seg_en === want) found = 1;
    end
    chk({tag, "_slot"}, 32'(found), 32'd1);
    chk({tag, "_code"}, 32'(code_to_display), 32'(c));
    chk({tag, "_ext"}, 32'(ext_to_display), 32'(e));
  endtask

  // Expected enable after edge k comes from the index held before that edge.
  task automatic check_seg(input string tag, input int exp_cnt);
    int idx;
    logic [ND-1:0] want;
    idx  = ((edge_cnt - 1) / RD) % ND;
    want = ~(4'b0001 << idx);
`ifdef BLANK_EMPTY_EN
    if (idx >= exp_cnt) want = 4'hF;
`else
    if (exp_cnt < 0) want = 4'h0;
`endif
    chk(tag, 32'(seg_en), 32'(want));
  endtask

  initial begin
    // 1. reset state and idle scan sequence
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg_en), 32'hF);
    chk("rst_code", 32'(code_to_display), 32'h00);
    chk("rst_ext", 32'(ext_to_display), 32'h0);
    chk("rst_cnt", 32'(key_count), 32'h0);
    rst = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      logic [ND-1:0] want;
      @(negedge clk);
      want = ~(4'b0001 << (((k - 1) / 4) % 4));
`ifdef BLANK_EMPTY_EN
      want = 4'hF;
`endif
      chk($sformatf("idle_seg_%0d", k), 32'(seg_en), 32'(want));
      chk($sformatf("idle_code_%0d", k), 32'(code_to_display), 32'h00);
    end
    chk("idle_cnt", 32'(key_count), 32'h0);

    // 2. two plain break sequences
    send(8'h1C); send(8'hF0); send(8'h1C);
    chk("p1_cnt", 32'(key_count), 32'd1);
    check_digit(0, 8'h1C, 1'b0, "p1_d0");
    send(8'h32); send(8'hF0); send(8'h32);
    chk("p2_cnt", 32'(key_count), 32'd2);
    check_digit(0, 8'h32, 1'b0, "p2_d0");
    check_digit(1, 8'h1C, 1'b0, "p2_d1");

    // 3. extended break pushes with ext; extended make does not push
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("x_cnt", 32'(key_count), 32'd3);
    check_digit(0, 8'h75, 1'b1, "x_d0");
    check_digit(1, 8'h32, 1'b0, "x_d1");
    send(8'hE0); send(8'h75);
    chk("xm_cnt", 32'(key_count), 32'd3);
    check_digit(0, 8'h75, 1'b1, "xm_d0");

    // 4. overfill: oldest entries drop out, count saturates
    brk(8'h15);
    chk("sat_cnt1", 32'(key_count), 32'd4);
    brk(8'h1D); brk(8'h24); brk(8'h2D); brk(8'h2C); brk(8'h35);
    chk("sat_cnt6", 32'(key_count), 32'd4);
    check_digit(0, 8'h35, 1'b0, "sat_d0");
    check_digit(1, 8'h2C, 1'b0, "sat_d1");
    check_digit(2, 8'h2D, 1'b0, "sat_d2");
    check_digit(3, 8'h24, 1'b0, "sat_d3");

    // 5. error byte aborts a break; then F0 exactly on a refresh wrap
    send(8'hF0); send(8'hFF); send(8'h1C);
    chk("err_cnt", 32'(key_count), 32'd4);
    check_digit(0, 8'h35, 1'b0, "err_d0");
    begin
      int guard = 0;
      @(negedge clk);
      while (((edge_cnt + 1) % RD) != 0 && guard < 8) begin
        @(negedge clk);
        guard++;
      end
    end
    valid_code   = 1'b1;
    scan_code_in = 8'hF0;
    @(negedge clk);
    valid_code   = 1'b0;
    scan_code_in = 8'h00;
    chk("wrap_phase", 32'(edge_cnt % RD), 32'd0);
    @(negedge clk);
    check_seg("wrap_seg", 4);
    send(8'h1B);
    chk("wrap_cnt", 32'(key_count), 32'd4);
    check_digit(0, 8'h1B, 1'b0, "wrap_d0");
    check_digit(1, 8'h35, 1'b0, "wrap_d1");
    check_seg("wrap_seg2", 4);

    // 6. reset mid-sequence drops the pending break and clears the buffer
    send(8'hF0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cnt", 32'(key_count), 32'd0);
    chk("mid_rst_seg", 32'(seg_en), 32'hF);
    chk("mid_rst_code", 32'(code_to_display), 32'h00);
    rst = 1'b1;
    send(8'h1C);
    chk("post_rst_cnt", 32'(key_count), 32'd0);
`ifndef BLANK_EMPTY_EN
    check_digit(0, 8'h00, 1'b0, "post_rst_d0");
    check_digit(3, 8'h00, 1'b0, "post_rst_d3");
`endif
    brk(8'h1C);
    chk("one_cnt", 32'(key_count), 32'd1);
    check_digit(0, 8'h1C, 1'b0, "one_d0");
`ifdef BLANK_EMPTY_EN
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("blank_seg_%0d", k), 32'(seg_en === 4'hE || seg_en === 4'hF), 32'd1);
      if (seg_en === 4'hF) chk($sformatf("blank_code_%0d", k), 32'(code_to_display), 32'h00);
      check_seg($sformatf("blank_slot_%0d", k), 1);
    end
`else
    check_digit(1, 8'h00, 1'b0, "one_d1");
    check_seg("one_seg", 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
